shift_chain_arbiter: RTL and testbench
======================================

Name: shift_chain_arbiter

Overview:
- Shares one external serial shift chain (SISO delay line, DATA_W bits plus an output register) between NREQ parallel requesters.
- Arbitrates round-robin and accepts one parallel word per transaction. Serializes the word MSB-first onto the chain, then flushes the chain.
- Captures the returning serial stream and returns it as a parallel response tagged with the requester ID.
- Sits between word-level client logic and the shift-register datapath; the only block that drives the chain input.

Parameters:
- NREQ, 2, number of requesters (2..8)
- DATA_W, 8, word width and bits shifted per transaction (2..32)
- PIPE_LAT, 9, cycles from controller driving a bit on ser_out to that bit being sampled back from ser_in (0..31)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ*DATA_W  requester k word at bits [k*DATA_W +: DATA_W]
- req_ready  out  NREQ  one-hot accept, combinational
- ser_out  out  1  serial data to chain input, registered
- ser_en  out  1  high while a transaction occupies the chain (SHIFT or FLUSH), registered
- ser_in  in  1  serial data returning from chain output
- rsp_valid  out  1  response valid, registered
- rsp_data  out  DATA_W  captured word, MSB = first bit returned
- rsp_id  out  IDW  requester index of the response; IDW = clog2(NREQ), minimum 1
- rsp_ready  in  1  response consumer ready

Behaviour:
- Reset is asynchronous and active-high on clock clk. Reset values:
  - state IDLE; rr_ptr 0; cnt 0
  - ser_out 0; ser_en 0; rsp_valid 0; rsp_data 0; rsp_id 0
  - internal tx/rx shift registers 0
- Reset mid-transaction aborts it: no response is produced, and the partially shifted word is lost.
- States: IDLE, SHIFT, FLUSH, RESP.
- IDLE:
  - Grant g is the first k with req_valid[k]=1, searching rr_ptr, rr_ptr+1, ... wrapping modulo NREQ.
  - req_ready = one-hot(g) only in IDLE with any valid; req_ready = 0 in all other states.
  - On the accept edge:
    - tx_sr <= word << 1; ser_out <= word[DATA_W-1]; rsp_id <= g
    - rr_ptr <= (g+1) mod NREQ; cnt <= 0; ser_en <= 1
    - state <= SHIFT
- Cycle numbering: cnt = 0 is the first cycle after accept. ser_out carries word bit DATA_W-1-cnt during cycles cnt = 0..DATA_W-1, and 0 afterwards (zero flush).
- SHIFT covers cnt 0..DATA_W-1; FLUSH covers cnt DATA_W..DATA_W+PIPE_LAT-1. cnt increments every cycle; SHIFT→FLUSH when cnt reaches DATA_W-1. If PIPE_LAT = 0, FLUSH is skipped.
- Capture:
  - At the edge ending cycle cnt, if cnt >= PIPE_LAT: rx_sr <= {rx_sr[DATA_W-2:0], ser_in}.
  - Returned bit i (MSB first) is sampled at the end of cycle PIPE_LAT+i.
- At the edge ending the last cycle (cnt = DATA_W+PIPE_LAT-1):
  - the final bit is included, i.e. rsp_data <= {rx_sr[DATA_W-2:0], ser_in}
  - rsp_valid <= 1; ser_en <= 0; state <= RESP
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid <= 0, state <= IDLE. No new accept occurs in the same cycle.
- Occupancy: accept → rsp_valid = DATA_W+PIPE_LAT+1 edges. Minimum spacing between accepts is DATA_W+PIPE_LAT+2 cycles with rsp_ready tied high.
- req_valid deasserting while not granted is legal; no request is latched.
- Granted data is sampled only on the accept edge.
- ser_in is ignored outside the capture window.

Test Plan:
1. PIPE_LAT=9, 8-bit SISO chain model on ser_out→ser_in, req_valid=01, word 0xA5 → ser_out 1,0,1,0,0,1,0,1 in cycles 0..7; ser_en high 17 cycles; rsp_valid on edge 18 with rsp_data=0xA5, rsp_id=0.
2. Both req_valid held high, words 0x11/0x22, rsp_ready=1 → accepts alternate 0,1,0,1; responses 0x11 id0, 0x22 id1, 0x11 id0; no requester granted twice consecutively.
3. rsp_ready held low 5 cycles after rsp_valid → rsp_valid/rsp_data/rsp_id stable; req_ready stays 0; handshake then IDLE, next accept one cycle later.
4. rst asserted at cnt=3 of SHIFT, between edges → ser_out, ser_en, rsp_valid go 0 immediately; no response; after release, first grant goes to requester 0.
5. PIPE_LAT=0, ser_in wired to ser_out, word 0x3C → ser_en high 8 cycles, rsp_data=0x3C.
6. PIPE_LAT=9, ser_in tied 1, word 0x00 → rsp_data=0xFF; ser_in toggled only during cycles 0..8 → no effect on rsp_data.

Source files
------------

// File: rtl/shift_chain_arbiter.sv
`default_nettype none
// ============================================================================
// shift_chain_arbiter : round-robin access to a shared serial shift chain;
// serializes one word MSB-first, flushes, and returns the captured word.
// Revision: 1.0
// ============================================================================
module shift_chain_arbiter #(
   parameter int NREQ     = 2,
   parameter int DATA_W   = 8,
   parameter int PIPE_LAT = 9,
   localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic                     ser_out,
   output logic                     ser_en,
   input  logic                     ser_in,
   output logic                     rsp_valid,
   output logic [DATA_W-1:0]        rsp_data,
   output logic [IDW-1:0]           rsp_id,
   input  logic                     rsp_ready
);

   localparam int CNTW = $clog2(DATA_W + PIPE_LAT);
   localparam logic [CNTW-1:0] SHIFT_END = CNTW'(DATA_W - 1);
   localparam logic [CNTW-1:0] LAST_CNT  = CNTW'(DATA_W + PIPE_LAT - 1);
   localparam logic [CNTW-1:0] CAP_START = CNTW'(PIPE_LAT);

   typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, RESP} state_t;

   state_t              state;
   logic [IDW-1:0]      rr_ptr;
   logic [CNTW-1:0]     cnt;
   logic [DATA_W-1:0]   tx_sr;
   logic [DATA_W-2:0]   rx_sr;
   logic [IDW-1:0]      grant;
   logic                any_valid;
   logic [DATA_W-1:0]   acc_word;

   // Rotating priority search starting at rr_ptr.
   always_comb begin
      any_valid = 1'b0;
      grant     = '0;
      for (int i = 0; i < NREQ; i++) begin
         int k;
         k = int'(rr_ptr) + i;
         if (k >= NREQ) k = k - NREQ;
         if (!any_valid && req_valid[k]) begin
            any_valid = 1'b1;
            grant     = k[IDW-1:0];
         end
      end
   end

   assign req_ready = (state == IDLE && any_valid) ? (NREQ'(1) << grant) : '0;
   assign acc_word  = req_data[grant*DATA_W +: DATA_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cnt       <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         ser_out   <= 1'b0;
         ser_en    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  tx_sr   <= acc_word << 1;
                  ser_out <= acc_word[DATA_W-1];
                  rsp_id  <= grant;
                  rr_ptr  <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                  cnt     <= '0;
                  rx_sr   <= '0;
                  ser_en  <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT, FLUSH: begin
               // tx_sr runs out of data bits after DATA_W-1 shifts, giving the zero flush.
               cnt     <= cnt + 1'b1;
               tx_sr   <= tx_sr << 1;
               ser_out <= tx_sr[DATA_W-1];
               if (cnt >= CAP_START) rx_sr <= (DATA_W-1)'({rx_sr, ser_in});
               if (cnt == LAST_CNT) begin
                  rsp_data  <= {rx_sr, ser_in};
                  rsp_valid <= 1'b1;
                  ser_en    <= 1'b0;
                  ser_out   <= 1'b0;
                  state     <= RESP;
               end else if (cnt == SHIFT_END) begin
                  state <= FLUSH;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_shift_chain_arbiter.sv
`default_nettype none
// ============================================================================
// tb_shift_chain_arbiter : randomized bench with a transaction-level model.
// Revision: 1.0
// ============================================================================
module tb_shift_chain_arbiter;
   localparam int NR  = 2;
   localparam int DW  = 8;
   localparam int PL  = 9;
   localparam int IDW = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [NR-1:0]     req_valid, req_ready;
   logic [NR*DW-1:0]  req_data;
   logic              ser_out, ser_en, ser_in, rsp_valid, rsp_ready;
   logic [DW-1:0]     rsp_data;
   logic [IDW-1:0]    rsp_id;

   logic [PL-1:0]     chain;
   logic              ser_mode, ser_drv;

   // External chain: PL-cycle delay line from ser_out back to ser_in.
   always @(posedge clk) chain <= {chain[PL-2:0], ser_out};
   assign ser_in = ser_mode ? ser_drv : chain[PL-1];

   shift_chain_arbiter #(.NREQ(NR), .DATA_W(DW), .PIPE_LAT(PL)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .ser_out(ser_out), .ser_en(ser_en), .ser_in(ser_in),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
      .rsp_ready(rsp_ready)
   );

   logic [NR-1:0]     req_valid0, req_ready0;
   logic [NR*DW-1:0]  req_data0;
   logic              ser_out0, ser_en0, rsp_valid0;
   logic [DW-1:0]     rsp_data0;
   logic [IDW-1:0]    rsp_id0;

   shift_chain_arbiter #(.NREQ(NR), .DATA_W(DW), .PIPE_LAT(0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid0), .req_data(req_data0), .req_ready(req_ready0),
      .ser_out(ser_out0), .ser_en(ser_en0), .ser_in(ser_out0),
      .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .rsp_id(rsp_id0),
      .rsp_ready(1'b1)
   );

   int vectors = 0;
   int miscompares = 0;
   int model_ptr = 0;
   logic [DW-1:0] w5;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) begin
         int k;
         k = (model_ptr + i) % NR;
         if (v[k]) return k;
      end
      return -1;
   endfunction

   // Entered and left just after a falling edge.
   task automatic txn(input logic [NR-1:0] v, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                      input int hold, input bit mode);
      int g;
      logic [DW-1:0] w, expd;
      req_valid = v;
      req_data  = {w1, w0};
      ser_mode  = mode;
      ser_drv   = 1'b1;
      rsp_ready = 1'b0;
      #1;
      g = pick(v);
      if (g < 0) begin
         chk("idle_ready", req_ready, 0);
         @(negedge clk);
         return;
      end
      chk("grant", req_ready, 1 << g);
      w = req_data[g*DW +: DW];
      model_ptr = (g + 1) % NR;
      expd = mode ? '1 : w;
      @(posedge clk);
      #1;
      req_valid = NR'($urandom);
      req_data  = (NR*DW)'($urandom);
      for (int c = 0; c < DW + PL; c++) begin
         @(negedge clk);
         ser_drv = (c < PL) ? 1'($urandom) : 1'b1;
         chk("ser_en", ser_en, 1);
         chk("ser_out", ser_out, (c < DW) ? w[DW-1-c] : 1'b0);
         chk("busy_ready", req_ready, 0);
         chk("busy_rsp_valid", rsp_valid, 0);
      end
      @(negedge clk);
      chk("rsp_valid", rsp_valid, 1);
      chk("ser_en_off", ser_en, 0);
      chk("rsp_data", rsp_data, expd);
      chk("rsp_id", rsp_id, g);
      req_valid = v;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_data", rsp_data, expd);
         chk("hold_id", rsp_id, g);
         chk("hold_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("rsp_done", rsp_valid, 0);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      req_valid = '0; req_data = '0; rsp_ready = 1'b0;
      ser_mode = 1'b0; ser_drv = 1'b1;
      req_valid0 = '0; req_data0 = '0;
      repeat (3) @(negedge clk);
      chk("rst_ser_out", ser_out, 0);
      chk("rst_ser_en", ser_en, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_req_ready", req_ready, 0);
      rst = 1'b0;
      @(negedge clk);

      txn(2'b01, 8'hA5, 8'h00, 0, 1'b0);
      repeat (4) txn(2'b11, 8'h11, 8'h22, 0, 1'b0);
      txn(2'b11, 8'h5A, 8'hC3, 5, 1'b0);
      txn(2'b01, 8'h00, 8'h00, 0, 1'b1);

      // Abort mid-shift: accept requester 0, reset during cycle 3.
      req_valid = 2'b01; req_data = {8'h00, 8'h96}; ser_mode = 1'b0;
      @(posedge clk);
      #1 req_valid = '0;
      repeat (4) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_ser_out", ser_out, 0);
      chk("abort_ser_en", ser_en, 0);
      chk("abort_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      model_ptr = 0;
      repeat (12) begin
         @(negedge clk);
         chk("abort_no_rsp", rsp_valid, 0);
      end
      txn(2'b11, 8'h3E, 8'h7F, 0, 1'b0);

      for (int t = 0; t < 40; t++)
         txn(NR'($urandom), DW'($urandom), DW'($urandom), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));

      // Zero-latency loopback instance.
      for (int t = 0; t < 4; t++) begin
         w5 = (t == 0) ? 8'h3C : DW'($urandom);
         req_valid0 = 2'b01;
         req_data0  = {8'h00, w5};
         #1 chk("l0_grant", req_ready0, 2'b01);
         @(posedge clk);
         #1 req_valid0 = '0;
         for (int c = 0; c < DW; c++) begin
            @(negedge clk);
            chk("l0_ser_en", ser_en0, 1);
            chk("l0_ser_out", ser_out0, w5[DW-1-c]);
         end
         @(negedge clk);
         chk("l0_rsp_valid", rsp_valid0, 1);
         chk("l0_ser_en_off", ser_en0, 0);
         chk("l0_rsp_data", rsp_data0, w5);
         chk("l0_rsp_id", rsp_id0, 0);
         @(negedge clk);
         chk("l0_rsp_done", rsp_valid0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
